// File: rtl/lgn_image_loader_if.sv
// rtl/lgn_image_loader_if.sv - image-in / popcount-out handshake bundle for lgn_image_loader
interface lgn_image_loader_if #(
    parameter int INPUTS = 256,
    parameter int SUM_W  = 15
);
    logic              img_valid;
    logic              img_ready;
    logic [INPUTS-1:0] img_data;
    logic              res_valid;
    logic              res_ready;
    logic [SUM_W-1:0]  res_sum;
    logic              res_unstable;

    modport master (
        output img_valid, img_data, res_ready,
        input  img_ready, res_valid, res_sum, res_unstable
    );

    modport slave (
        input  img_valid, img_data, res_ready,
        output img_ready, res_valid, res_sum, res_unstable
    );
endinterface

// File: rtl/lgn_image_loader.sv
// rtl/lgn_image_loader.sv - streams a binarised image MSB-byte-first into the LGN chip and returns its popcount
// Optional stable-sample verification is enabled by defining LGN_LOADER_STABLE_SAMPLE_EN.
module lgn_image_loader #(
    parameter int INPUTS        = 256,
    parameter int BYTE_W        = 8,
    parameter int SUM_W         = 15,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    lgn_image_loader_if.slave  bus,
    output logic [BYTE_W-1:0]  pad_data,
    output logic               pad_load_n,
    input  logic [SUM_W-1:0]   pad_sum_in,
    output logic               busy
);

    localparam int NBYTES = INPUTS / BYTE_W;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);

`ifdef LGN_LOADER_STABLE_SAMPLE_EN
    typedef enum logic [2:0] {IDLE, SHIFT, SETTLE, VERIFY, RESULT} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, SETTLE, RESULT} state_t;
`endif

    state_t             state_q;
    logic [INPUTS-1:0]  buf_q;
    logic [CNT_W-1:0]   byte_cnt_q;
    logic [SET_W-1:0]   settle_cnt_q;
    logic [BYTE_W-1:0]  pad_data_q;
    logic               pad_load_n_q;
    logic               res_valid_q;
    logic [SUM_W-1:0]   res_sum_q;

`ifdef LGN_LOADER_STABLE_SAMPLE_EN
    logic [SUM_W-1:0]   sample_q;
    logic [3:0]         retry_q;
    logic               res_unstable_q;
`endif

    assign pad_data         = pad_data_q;
    assign pad_load_n       = pad_load_n_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_sum      = res_sum_q;
    assign bus.img_ready    = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
`ifdef LGN_LOADER_STABLE_SAMPLE_EN
    assign bus.res_unstable = res_unstable_q;
`else
    assign bus.res_unstable = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            byte_cnt_q   <= '0;
            settle_cnt_q <= '0;
            pad_data_q   <= '0;
            pad_load_n_q <= 1'b1;
            res_valid_q  <= 1'b0;
            res_sum_q    <= '0;
`ifdef LGN_LOADER_STABLE_SAMPLE_EN
            sample_q       <= '0;
            retry_q        <= '0;
            res_unstable_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.img_valid) begin
                        // Byte 0 goes out with the strobe; the buffer keeps the rest top-aligned.
                        pad_data_q   <= bus.img_data[INPUTS-1 -: BYTE_W];
                        buf_q        <= bus.img_data << BYTE_W;
                        pad_load_n_q <= 1'b0;
                        byte_cnt_q   <= CNT_W'(1);
                        state_q      <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (byte_cnt_q == CNT_W'(NBYTES)) begin
                        pad_load_n_q <= 1'b1;
                        pad_data_q   <= '0;
                        byte_cnt_q   <= '0;
                        settle_cnt_q <= '0;
                        state_q      <= SETTLE;
                    end else begin
                        pad_data_q <= buf_q[INPUTS-1 -: BYTE_W];
                        buf_q      <= buf_q << BYTE_W;
                        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                    end
                end

                SETTLE: begin
                    if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
`ifdef LGN_LOADER_STABLE_SAMPLE_EN
                        sample_q <= pad_sum_in;
                        retry_q  <= '0;
                        state_q  <= VERIFY;
`else
                        res_sum_q   <= pad_sum_in;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
`endif
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SET_W'(1);
                    end
                end

`ifdef LGN_LOADER_STABLE_SAMPLE_EN
                VERIFY: begin
                    if (pad_sum_in == sample_q) begin
                        res_sum_q      <= sample_q;
                        res_valid_q    <= 1'b1;
                        res_unstable_q <= 1'b0;
                        state_q        <= RESULT;
                    end else if (retry_q == 4'd14) begin
                        // Fifteenth disagreement: give up and flag the latest sample.
                        res_sum_q      <= pad_sum_in;
                        res_valid_q    <= 1'b1;
                        res_unstable_q <= 1'b1;
                        retry_q        <= retry_q + 4'd1;
                        state_q        <= RESULT;
                    end else begin
                        sample_q <= pad_sum_in;
                        retry_q  <= retry_q + 4'd1;
                    end
                end
`endif

                RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lgn_image_loader.sv
// tb/tb_lgn_image_loader.sv - scoreboard bench for lgn_image_loader with a behavioural chip shift model
module tb_lgn_image_loader;

    localparam int INPUTS = 256;
    localparam int BYTE_W = 8;
    localparam int SUM_W  = 15;
    localparam int NB     = INPUTS / BYTE_W;
`ifdef LGN_LOADER_STABLE_SAMPLE_EN
    localparam int LAT = NB + 2 + 1;
`else
    localparam int LAT = NB + 2;
`endif

    typedef struct {
        logic [SUM_W-1:0] sum;
        bit               any;
        bit               unst;
        int               lat;
    } res_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [BYTE_W-1:0] pad_data;
    logic              pad_load_n;
    logic [SUM_W-1:0]  pad_sum_in = '0;
    logic              busy;

    int tests = 0;
    int fails = 0;

    logic [INPUTS-1:0] img_q[$];
    res_t              res_q[$];

    lgn_image_loader_if #(.INPUTS(INPUTS), .SUM_W(SUM_W)) bus ();

    lgn_image_loader #(
        .INPUTS(INPUTS), .BYTE_W(BYTE_W), .SUM_W(SUM_W), .SETTLE_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .pad_data   (pad_data),
        .pad_load_n (pad_load_n),
        .pad_sum_in (pad_sum_in),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [INPUTS-1:0] act, input logic [INPUTS-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [INPUTS-1:0] rand_img();
        logic [INPUTS-1:0] v;
        for (int i = 0; i < INPUTS / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Chip model: every strobe-low cycle shifts one byte in at the bottom.
    logic [INPUTS-1:0] chip = '0;
    logic [SUM_W-1:0]  held_sum = '0;
    int  cyc = 0, acc_cyc = 0, low_cnt = 0;
    bit  prev_rst = 1'b0, res_seen = 1'b0;

    always @(negedge clk) begin
        res_t e;
        cyc++;
        if (prev_rst) begin
            check("rst_load_n", pad_load_n, 1);
            check("rst_res_valid", bus.res_valid, 0);
            check("rst_busy", busy, 0);
            img_q.delete();
            res_q.delete();
            low_cnt  = 0;
            res_seen = 1'b0;
        end else begin
            if (pad_load_n === 1'b0) begin
                chip = {chip[INPUTS-BYTE_W-1:0], pad_data};
                low_cnt++;
            end else if (low_cnt != 0) begin
                if (img_q.size() == 0) check("unexpected_load", 1, 0);
                else check("chip_image", chip, img_q.pop_front());
                check("load_n_low_cycles", low_cnt, NB);
                low_cnt = 0;
            end
            if (pad_load_n === 1'b1) check("pad_data_idle_zero", pad_data, 0);
            if (bus.res_valid === 1'b1) begin
                check("img_ready_in_result", bus.img_ready, 0);
                check("load_n_in_result", pad_load_n, 1);
                if (!res_seen) begin
                    res_seen = 1'b1;
                    held_sum = bus.res_sum;
                    if (res_q.size() == 0) check("unexpected_result", 1, 0);
                    else begin
                        e = res_q.pop_front();
                        if (e.any) check("res_sum_either", (bus.res_sum == 15'd7 || bus.res_sum == 15'd9), 1);
                        else check("res_sum", bus.res_sum, e.sum);
                        check("res_unstable", bus.res_unstable, e.unst);
                        if (e.lat > 0) check("latency", cyc - acc_cyc - 1, e.lat);
                    end
                end else begin
                    check("res_sum_stable", bus.res_sum, held_sum);
                end
                if (bus.res_ready) res_seen = 1'b0;
            end
            if (bus.img_valid && bus.img_ready === 1'b1) acc_cyc = cyc;
        end
        prev_rst = rst;
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.img_valid = 1'b0;
        bus.res_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_image(input logic [INPUTS-1:0] img, input logic [SUM_W-1:0] sum,
                              input bit any, input bit unst, input int lat);
        res_t e;
        bit ok = 1'b0;
        pad_sum_in    = sum;
        bus.img_data  = img;
        bus.img_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.img_ready === 1'b1 && !rst) ok = 1'b1;
        end
        check("accept_timeout", ok, 1);
        if (ok) begin
            e.sum = sum; e.any = any; e.unst = unst; e.lat = lat;
            img_q.push_back(img);
            res_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.img_valid = 1'b0;
        bus.img_data  = rand_img();
    endtask

    task automatic wait_result(input int delay, input bit toggle);
        bit done = 1'b0, hs = 1'b0;
        int held = 0;
        bus.res_ready = (delay == 0);
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            #1;
            if (toggle) pad_sum_in = (pad_sum_in == 15'd7) ? 15'd9 : 15'd7;
            if (hs) done = 1'b1;
            else if (bus.res_valid) begin
                if (held >= delay) bus.res_ready = 1'b1;
                held++;
                if (bus.res_ready) hs = 1'b1;
            end
        end
        check("result_timeout", done, 1);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        logic [INPUTS-1:0] img;
        bit seen;
        bus.img_valid = 1'b0;
        bus.img_data  = '0;
        bus.res_ready = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_load_n", pad_load_n, 1);
        check("reset_pad_data", pad_data, 0);
        check("reset_res_valid", bus.res_valid, 0);
        check("reset_res_sum", bus.res_sum, 0);
        check("reset_res_unstable", bus.res_unstable, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        check("reset_img_ready", bus.img_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < NB; i++) img[INPUTS-1-8*i -: 8] = 8'(i);
        send_image(img, 15'd1234, 1'b0, 1'b0, LAT);
        wait_result(0, 1'b0);
        check("idle_after_result", bus.img_ready, 1);

        for (int n = 0; n < 6; n++) begin
            send_image(rand_img(), SUM_W'($urandom), 1'b0, 1'b0, LAT);
            wait_result($urandom_range(0, 3), 1'b0);
        end

        // Backpressure with a second image already waiting on the bus.
        send_image(rand_img(), SUM_W'($urandom), 1'b0, 1'b0, LAT);
        img = rand_img();
        bus.img_data  = img;
        bus.img_valid = 1'b1;
        wait_result(10, 1'b0);
        send_image(img, SUM_W'($urandom), 1'b0, 1'b0, LAT);
        wait_result(0, 1'b0);

        send_image(rand_img(), SUM_W'($urandom), 1'b0, 1'b0, LAT);
        repeat (9) @(posedge clk);
        #1;
        do_reset(1);
        for (int i = 0; i < NB; i++) img[INPUTS-1-8*i -: 8] = (i % 2 == 0) ? 8'hAA : 8'h55;
        send_image(img, 15'd77, 1'b0, 1'b0, LAT);
        wait_result(0, 1'b0);

        // Reset while a result is pending, with competing handshakes asserted.
        send_image(rand_img(), SUM_W'($urandom), 1'b0, 1'b0, LAT);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = bus.res_valid;
        end
        check("result_before_reset", seen, 1);
        bus.res_ready = 1'b1;
        bus.img_valid = 1'b1;
        do_reset(1);

`ifdef LGN_LOADER_STABLE_SAMPLE_EN
        send_image(rand_img(), 15'd500, 1'b0, 1'b0, LAT);
        wait_result(0, 1'b0);
        send_image(rand_img(), 15'd7, 1'b1, 1'b1, 0);
        wait_result(0, 1'b1);
`endif

        send_image(rand_img(), SUM_W'($urandom), 1'b0, 1'b0, LAT);
        wait_result(2, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", img_q.size() + res_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
